mem_responder: RTL and testbench

- Memory-side responder for the processor's single shared memory bus.
- Accepts read/write strobes with address and write data, holds them for a programmable number of wait states, then returns read data with a one-cycle ready pulse.
- Sits between the top-level memory port of the processor and a word-organised storage array.
- Serves as the bench and FPGA memory model, with variable latency, so that the processor's stall logic is exercised.

---
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-organised memory model with programmable wait states and a one-cycle ready pulse.
// Optional build macro MEM_RESP_RANGE_CHECK_EN adds mem_err for addresses beyond the storage range.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ADDR_LSB    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        mem_wr,
   input  logic        mem_re,
   output logic [31:0] data_out,
   output logic        mem_ready
`ifdef MEM_RESP_RANGE_CHECK_EN
   ,
   output logic        mem_err
`endif
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam int         HI_LSB   = ADDR_LSB + IDX_W;
   localparam bit         LAT_ZERO = (LATENCY == 0);
   localparam logic [7:0] LAT_INIT = LAT_ZERO ? 8'd0 : 8'(LATENCY - 1);
`ifdef MEM_RESP_RANGE_CHECK_EN
   localparam bit         CHK_EN   = 1'b1;
`else
   localparam bit         CHK_EN   = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        wr_q;
   logic [31:0] data_out_q;
   logic        mem_ready_q;
`ifdef MEM_RESP_RANGE_CHECK_EN
   logic        err_q;
`endif

   logic [31:0] mem_q [DEPTH_WORDS];

   logic             acc_go;
   logic             acc_wr;
   logic             acc_err;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_data;
   logic [IDX_W-1:0] acc_idx;

   function automatic logic out_of_range(input logic [31:0] a);
      return (a >> HI_LSB) != 32'd0;
   endfunction

   // Select which access (if any) completes on this edge; with zero latency the live bus is used directly.
   always_comb begin
      acc_go   = 1'b0;
      acc_wr   = wr_q;
      acc_addr = addr_q;
      acc_data = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (LAT_ZERO && (mem_re || mem_wr)) begin
               acc_go   = 1'b1;
               acc_wr   = mem_wr;
               acc_addr = addr;
               acc_data = data_in;
            end else begin
               acc_go   = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
               acc_go = 1'b1;
            end else begin
               acc_go = 1'b0;
            end
         end
         default: acc_go = 1'b0;
      endcase
      acc_idx = acc_addr[ADDR_LSB +: IDX_W];
      acc_err = CHK_EN && out_of_range(acc_addr);
   end

   // Storage array: no reset, contents survive rst; writes land on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (!rst && acc_go && acc_wr && !acc_err) begin
         mem_q[acc_idx] <= acc_data;
      end
   end

   // Request FSM with registered handshake and read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         wr_q        <= 1'b0;
         data_out_q  <= 32'd0;
         mem_ready_q <= 1'b0;
`ifdef MEM_RESP_RANGE_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         mem_ready_q <= 1'b0;
`ifdef MEM_RESP_RANGE_CHECK_EN
         err_q       <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (mem_re || mem_wr) begin
                  addr_q  <= addr;
                  wdata_q <= data_in;
                  wr_q    <= mem_wr;
                  if (LAT_ZERO) begin
                     state_q     <= S_RESP;
                     mem_ready_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= LAT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 8'd0) begin
                  state_q     <= S_RESP;
                  mem_ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            S_RESP: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (acc_go) begin
            if (!acc_wr) begin
               data_out_q <= acc_err ? 32'hDEAD_BEEF : mem_q[acc_idx];
            end
`ifdef MEM_RESP_RANGE_CHECK_EN
            err_q <= acc_err;
`endif
         end
      end
   end

   assign data_out  = data_out_q;
   assign mem_ready = mem_ready_q;
`ifdef MEM_RESP_RANGE_CHECK_EN
   assign mem_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY=2/1024 words, LATENCY=0/64 words).
// A driver pushes expected responses from an array model; a negedge monitor pops and compares.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_v;
   logic [1:0]       wr_v;
   logic [1:0]       re_v;
   logic [1:0]       rdy_v;
   logic [1:0][31:0] addr_v;
   logic [1:0][31:0] din_v;
   logic [1:0][31:0] dout_v;
`ifdef MEM_RESP_RANGE_CHECK_EN
   logic [1:0]       err_v;
   localparam bit    CHK = 1'b1;
`else
   localparam bit    CHK = 1'b0;
`endif

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_LSB(2)) dut0 (
      .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .data_in(din_v[0]),
      .mem_wr(wr_v[0]), .mem_re(re_v[0]), .data_out(dout_v[0]), .mem_ready(rdy_v[0])
`ifdef MEM_RESP_RANGE_CHECK_EN
      , .mem_err(err_v[0])
`endif
   );

   mem_responder #(.DEPTH_WORDS(64), .LATENCY(0), .ADDR_LSB(2)) dut1 (
      .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .data_in(din_v[1]),
      .mem_wr(wr_v[1]), .mem_re(re_v[1]), .data_out(dout_v[1]), .mem_ready(rdy_v[1])
`ifdef MEM_RESP_RANGE_CHECK_EN
      , .mem_err(err_v[1])
`endif
   );

   typedef struct {
      logic [31:0] dout;
      int          due;
      bit          err;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mdl [2][1024];
   logic [31:0] last_rd [2];
   int          nxt [2];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lg(input int d);
      return (d == 0) ? 10 : 6;
   endfunction

   function automatic int lat(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rdy_v[d] === 1'b1) begin
            exp_t e;
            bit   got;
            got = 1'b0;
            if (d == 0 && q0.size() > 0) begin
               e = q0.pop_front();
               got = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
               e = q1.pop_front();
               got = 1'b1;
            end
            if (!got) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_ready dut%0d: got ready=1 expected 0 at cycle %0d", d, cyc);
            end else begin
               chk($sformatf("data_out_dut%0d", d), dout_v[d], e.dout);
               chk($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.due));
`ifdef MEM_RESP_RANGE_CHECK_EN
               chk($sformatf("mem_err_dut%0d", d), {31'd0, err_v[d]}, {31'd0, e.err});
`endif
            end
         end
      end
   end

   // Issue one request at the current negedge, predict its response, wait for the pulse.
   task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input bit wr, input bit re, input int gap);
      int   acc;
      int   idx;
      int   hi;
      bit   err;
      bit   seen;
      exp_t e;
      acc = (cyc + 1 > nxt[d]) ? cyc + 1 : nxt[d];
      addr_v[d] = a;
      din_v[d]  = wd;
      wr_v[d]   = wr;
      re_v[d]   = re;
      idx = int'(a >> 2) & ((1 << lg(d)) - 1);
      hi  = int'(a >> (2 + lg(d)));
      err = CHK && (hi != 0);
      if (wr) begin
         if (!err) mdl[d][idx] = wd;
         e.dout = last_rd[d];
      end else begin
         e.dout = err ? 32'hDEAD_BEEF : mdl[d][idx];
         last_rd[d] = e.dout;
      end
      e.due = acc + lat(d);
      e.err = err;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = (rdy_v[d] === 1'b1);
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout dut%0d: got no ready expected one by cycle %0d", d, e.due);
         if (d == 0) q0.delete();
         else q1.delete();
      end
      nxt[d] = cyc + 2;
      if (gap > 0) begin
         wr_v[d] = 1'b0;
         re_v[d] = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      int acc;
      rst_v  = 2'b11;
      wr_v   = 2'b00;
      re_v   = 2'b00;
      addr_v = '0;
      din_v  = '0;
      for (int d = 0; d < 2; d++) begin
         last_rd[d] = 32'd0;
         nxt[d]     = 0;
      end
      repeat (3) @(negedge clk);
      rst_v = 2'b00;

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_data_out_dut%0d", d), dout_v[d], 32'd0);
         chk($sformatf("reset_ready_dut%0d", d), {31'd0, rdy_v[d]}, 32'd0);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ready_dut0", {31'd0, rdy_v[0]}, 32'd0);
      end

      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 9; w++) begin
            do_req(d, 32'(w * 4), $urandom, 1'b1, 1'b0, $urandom_range(0, 2));
         end
      end

      do_req(0, 32'h10, 32'hCAFE_F00D, 1'b1, 1'b0, 1);
      do_req(0, 32'h10, 32'd0, 1'b0, 1'b1, 1);
      do_req(0, 32'h8, 32'h1234_5678, 1'b1, 1'b1, 1);
      do_req(0, 32'h8, 32'd0, 1'b0, 1'b1, 0);
      do_req(0, 32'h1000, 32'h11, 1'b1, 1'b0, 2);
      do_req(0, 32'h0, 32'd0, 1'b0, 1'b1, 0);
      do_req(0, 32'h1000, 32'd0, 1'b0, 1'b1, 1);

      do_req(1, 32'h0, 32'd0, 1'b0, 1'b1, 0);
      do_req(1, 32'h4, 32'd0, 1'b0, 1'b1, 0);
      do_req(1, 32'h0, 32'd0, 1'b0, 1'b1, 0);
      do_req(1, 32'h4, 32'd0, 1'b0, 1'b1, 1);

      do_req(0, 32'h20, 32'hAAAA_5555, 1'b1, 1'b0, 1);
      acc = (cyc + 1 > nxt[0]) ? cyc + 1 : nxt[0];
      addr_v[0] = 32'h20;
      din_v[0]  = 32'h1;
      wr_v[0]   = 1'b1;
      for (int i = 0; i < 20 && cyc < acc + 1; i++) @(negedge clk);
      rst_v[0] = 1'b1;
      wr_v[0]  = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_ready", {31'd0, rdy_v[0]}, 32'd0);
      chk("midreset_data_out", dout_v[0], 32'd0);
      rst_v[0]   = 1'b0;
      last_rd[0] = 32'd0;
      nxt[0]     = 0;
      @(negedge clk);
      do_req(0, 32'h20, 32'd0, 1'b0, 1'b1, 1);

      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          op;
            op = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 8) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + (32'($urandom_range(1, 7)) << (2 + lg(d)));
            do_req(d, a, $urandom, op != 0, op != 1, $urandom_range(0, 2));
         end
      end

      wr_v = 2'b00;
      re_v = 2'b00;
      repeat (5) @(negedge clk);
      chk("scoreboard_drain_dut0", 32'(q0.size()), 32'd0);
      chk("scoreboard_drain_dut1", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
